// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID instruction queue: bus widths and the default depth.
package if_id_queue_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam int QueueDepth  = 4;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side and decode-side valid/ready handshake bundle for the IF/ID queue.
interface if_id_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              if_valid;
    logic              if_ready;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;

    // master drives fetch words in and consumes decode words out
    modport master (
        output if_valid, if_pc, if_inst, id_ready,
        input  if_ready, id_valid, id_pc, id_inst
    );

    modport slave (
        input  if_valid, if_pc, if_inst, id_ready,
        output if_ready, id_valid, id_pc, id_inst
    );
endinterface

// File: rtl/if_id_queue_mem.sv
// Register array for the IF/ID queue: synchronous write, asynchronous read, so the
// head entry falls through to decode the cycle after it is written.
module if_id_queue_mem #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] entries [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (we && (waddr == IDX_W'(gi))) begin
                    entry_reg <= wdata;
                end
            end

            assign entries[gi] = entry_reg;
        end
    endgenerate

    assign rdata = entries[raddr];

endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry instruction queue between fetch and decode with flush and zero bubble on empty.
// Optional `IF_ID_PERF_EN adds a saturating flush_drops counter output.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int ADDR_W = InstAddrBus,
    parameter int INST_W = InstBus,
    parameter int DEPTH  = QueueDepth
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    if_id_queue_if.slave           bus,
    output logic [$clog2(DEPTH):0] count
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]            flush_drops
`endif
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int DATA_W = ADDR_W + INST_W;

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_next;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_data;

    // Pointers carry one wrap bit above the index so full and empty are distinguishable.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]) &&
                   (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]);

    assign push = bus.if_valid & ~full & ~flush;
    assign pop  = ~empty & bus.id_ready & ~flush;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    if_id_queue_mem #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_reg[IDX_W-1:0]),
        .wdata ({bus.if_pc, bus.if_inst}),
        .raddr (rd_ptr_reg[IDX_W-1:0]),
        .rdata (head_data)
    );

    // if_ready is purely state-derived so fetch never sees a path from id_ready.
    assign bus.if_ready = ~full;
    assign bus.id_valid = ~empty;
    assign bus.id_pc    = empty ? '0 : head_data[DATA_W-1:INST_W];
    assign bus.id_inst  = empty ? '0 : head_data[INST_W-1:0];
    assign count        = wr_ptr_reg - rd_ptr_reg;

`ifdef IF_ID_PERF_EN
    logic [31:0] flush_drops_reg;
    logic [31:0] flush_drops_next;
    logic [32:0] drop_sum;

    // A flush discards the current occupancy plus a word that would have been accepted.
    always_comb begin
        drop_sum         = {1'b0, flush_drops_reg} + 33'(count) + 33'(bus.if_valid & ~full);
        flush_drops_next = flush_drops_reg;
        if (flush) begin
            flush_drops_next = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_drops_reg <= '0;
        end else begin
            flush_drops_reg <= flush_drops_next;
        end
    end

    assign flush_drops = flush_drops_reg;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios then random traffic, checked by a
// queue-based reference model in a monitor sampling on the falling edge.
module tb_if_id_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [2:0]  count;
`ifdef IF_ID_PERF_EN
    logic [31:0] flush_drops;
    longint      exp_drops;
`endif

    int   total;
    int   bad;
    int   delivered;
    bit   seen_200;
    ent_t exp_q[$];

    if_id_queue_if #(.ADDR_W(32), .INST_W(32)) bus ();

    if_id_queue #(
        .ADDR_W (32),
        .INST_W (32),
        .DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus),
        .count (count)
`ifdef IF_ID_PERF_EN
        ,
        .flush_drops (flush_drops)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return ~pc ^ 32'h1357_9BDF;
    endfunction

    // Reference model: a plain queue updated from the inputs seen before each rising edge.
    always @(negedge clk) begin
        int n;
        ent_t e;
        if (bus.id_valid && bus.id_pc == 32'h200) seen_200 = 1'b1;
        if (!rst) begin
            exp_q.delete();
`ifdef IF_ID_PERF_EN
            exp_drops = 0;
`endif
            chk("rst_id_valid", {63'd0, bus.id_valid}, 64'd0);
            chk("rst_count", {61'd0, count}, 64'd0);
        end else begin
            n = exp_q.size();
            chk("id_valid", {63'd0, bus.id_valid}, {63'd0, n != 0});
            chk("if_ready", {63'd0, bus.if_ready}, {63'd0, n < DEPTH});
            chk("count", {61'd0, count}, 64'(n));
            if (n != 0) begin
                chk("id_pc", {32'd0, bus.id_pc}, {32'd0, exp_q[0].pc});
                chk("id_inst", {32'd0, bus.id_inst}, {32'd0, exp_q[0].inst});
            end else begin
                chk("bubble_pc", {32'd0, bus.id_pc}, 64'd0);
                chk("bubble_inst", {32'd0, bus.id_inst}, 64'd0);
            end
`ifdef IF_ID_PERF_EN
            chk("flush_drops", {32'd0, flush_drops}, exp_drops);
`endif
            if (flush) begin
`ifdef IF_ID_PERF_EN
                exp_drops = exp_drops + n + ((bus.if_valid && n < DEPTH) ? 1 : 0);
                if (exp_drops > 64'hFFFF_FFFF) exp_drops = 64'hFFFF_FFFF;
`endif
                exp_q.delete();
            end else begin
                if (bus.id_ready && n > 0) begin
                    e = exp_q.pop_front();
                    delivered++;
                    $display("deliver pc=%h inst=%h", e.pc, e.inst);
                end
                if (bus.if_valid && n < DEPTH) begin
                    e.pc   = bus.if_pc;
                    e.inst = bus.if_inst;
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        bus.if_valid = v;
        bus.if_pc    = pc;
        bus.if_inst  = inst_of(pc);
        bus.id_ready = rdy;
        flush        = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [31:0] pc;
        logic v, rdy, fl, acc;

        total = 0; bad = 0; delivered = 0; seen_200 = 1'b0;
        rst = 1'b0; flush = 1'b0;
        bus.if_valid = 1'b0; bus.if_pc = '0; bus.if_inst = '0; bus.id_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Fill with decode stalled, then a fifth word held by fetch.
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
        chk("full_if_ready", {63'd0, bus.if_ready}, 64'd0);
        chk("full_count", {61'd0, count}, 64'd4);
        drive(1'b1, 32'h110, 1'b0, 1'b0);
        chk("stall_id_pc", {32'd0, bus.id_pc}, 64'h100);
        chk("stall_count", {61'd0, count}, 64'd4);

        for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drained_valid", {63'd0, bus.id_valid}, 64'd0);
        chk("drained_pc", {32'd0, bus.id_pc}, 64'd0);

        // Steady state: one in, one out for 20 cycles at occupancy 1.
        drive(1'b1, 32'h400, 1'b0, 1'b0);
        d0 = delivered;
        for (int i = 1; i <= 20; i++) drive(1'b1, 32'h400 + 32'(4 * i), 1'b1, 1'b0);
        chk("steady_throughput", 64'(delivered - d0), 64'd20);
        chk("steady_count", {61'd0, count}, 64'd1);

        // Flush with a push and pop pending at occupancy 3.
        drive(1'b1, 32'h500, 1'b0, 1'b0);
        drive(1'b1, 32'h504, 1'b0, 1'b0);
        chk("preflush_count", {61'd0, count}, 64'd3);
        drive(1'b1, 32'h200, 1'b1, 1'b1);
        chk("flush_count", {61'd0, count}, 64'd0);
        chk("flush_valid", {63'd0, bus.id_valid}, 64'd0);
`ifdef IF_ID_PERF_EN
        chk("flush_drops_4", {32'd0, flush_drops}, 64'd4);
`endif
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("flushed_word_seen", {63'd0, seen_200}, 64'd0);

        // Full queue with simultaneous pop: push refused, accepted next cycle.
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h600 + 32'(4 * i), 1'b0, 1'b0);
        drive(1'b1, 32'h300, 1'b1, 1'b0);
        chk("fullpop_count", {61'd0, count}, 64'd3);
        chk("fullpop_if_ready", {63'd0, bus.if_ready}, 64'd1);
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        chk("fullpop_retry_count", {61'd0, count}, 64'd4);
        for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle with 3 entries queued.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h700 + 32'(4 * i), 1'b0, 1'b0);
        bus.if_valid = 1'b1; bus.if_pc = 32'h70C; bus.if_inst = inst_of(32'h70C);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_id_valid", {63'd0, bus.id_valid}, 64'd0);
        chk("arst_id_pc", {32'd0, bus.id_pc}, 64'd0);
        chk("arst_id_inst", {32'd0, bus.id_inst}, 64'd0);
        chk("arst_count", {61'd0, count}, 64'd0);
        chk("arst_if_ready", {63'd0, bus.if_ready}, 64'd1);
`ifdef IF_ID_PERF_EN
        chk("arst_flush_drops", {32'd0, flush_drops}, 64'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Random traffic; fetch holds its word until accepted and redirects on flush.
        pc = 32'h1000;
        for (int i = 0; i < 2000; i++) begin
            v   = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 29) == 0);
            acc = v && bus.if_ready && !fl;
            drive(v, pc, rdy, fl);
            if (fl) pc = 32'h1000 + ($urandom_range(0, 255) << 4);
            else if (acc) pc = pc + 32'd4;
        end
        for (int i = 0; i < 6; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("final_empty", {63'd0, bus.id_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
Parametrised successor of the single-stage IF/ID register: a DEPTH-entry instruction queue between fetch and decode.
- Valid/ready handshake on both sides, so decode can stall without losing fetched words.
- A flush input discards all queued entries on branch or exception redirect.
- Empty queue presents a zero bubble (pc=0, inst=0) to decode, the same as the legacy reset/empty case.

Parameters:
ADDR_W, 32, width of pc fields.
INST_W, 32, width of instruction fields.
DEPTH, 4, queue entries; power of two, >=2.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-low (0 = reset).
flush  in  1  discard all entries and the incoming push this cycle.
if_valid  in  1  fetch presents a word.
if_ready  out  1  queue accepts a word; equals !full.
if_pc  in  ADDR_W  fetch pc.
if_inst  in  INST_W  fetch instruction.
id_valid  out  1  head entry valid; equals !empty.
id_ready  in  1  decode consumes head this cycle.
id_pc  out  ADDR_W  head pc; 0 when empty.
id_inst  out  INST_W  head instruction; 0 when empty.
count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH x (ADDR_W+INST_W) array. wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits, with an extra wrap bit.
  - empty = pointers equal.
  - full = indices equal and wrap bits differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- Push = if_valid & if_ready & !flush. Pop = id_valid & id_ready & !flush.
- Latency: a word pushed at edge N is visible on id_* after edge N (first-word fall-through from registered storage). No same-cycle combinational pass-through.
- Ready rules:
  - if_ready depends only on state (!full). It has no combinational path from id_ready.
  - A full queue with simultaneous pop still deasserts if_ready. Occupancy drops and if_ready rises the next cycle.
- Simultaneous push and pop when not full and not empty: both take effect and count is unchanged.
- Push and pop on an empty queue: the push lands; the pop does not occur because id_valid=0.
- Output muxing: id_pc and id_inst are forced to 0 whenever empty. This applies to both the pc and inst fields.
- Flush is synchronous and has top priority.
  - At the next edge: wr_ptr=rd_ptr=0 and count=0.
  - The incoming fetch word and any pop that cycle are ignored.
  - Array contents need not be cleared.
- Reset is asynchronous. rst=0 immediately clears the pointers, so id_valid=0, id_pc=0, id_inst=0, count=0 and if_ready=1.
  - Reset mid-operation discards all entries.
  - Release is synchronised by the surrounding design.
- Holding id_ready=0 keeps id_pc/id_inst stable, which is the stall case.
- if_valid with if_ready=0: no state change. Fetch must hold its word.

Optional Feature:
IF_ID_PERF_EN
- Defined: adds output flush_drops (32 bits). Each flush adds the occupancy discarded by it (count, plus 1 if a push was attempted that cycle). The counter saturates at 32'hFFFF_FFFF and resets to 0.
- Undefined: the port and counter do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared constants stay in define.v: InstAddrBus, InstBus, ZeroWord, plus a new QueueDepth default.
- One natural sub-module: if_id_queue_mem. It is a synchronous-write, asynchronous-read register array, parametrised by width and depth.
- Pointer, flag and flush logic live in the top.

Test Plan:
- Reset: hold rst=0 mid-stream with 3 entries -> id_valid=0, id_pc=0, id_inst=0, count=0, if_ready=1 immediately, without waiting for a clock edge.
- Fill/stall: id_ready=0, push pc 0x100,0x104,0x108,0x10C -> count=4, if_ready=0 from the next cycle, id_pc stays 0x100; a 5th push is held by fetch.
- Drain order: then id_ready=1, if_valid=0 -> id_pc 0x100,0x104,0x108,0x10C on consecutive cycles; id_valid=0 and id_pc=0 afterwards.
- Steady state: continuous push/pop with count=1 -> count stays 1 and throughput is one instruction per cycle for 20 cycles; pointer wrap is exercised past 2*DEPTH.
- Flush priority: count=3 with flush=1, if_valid=1 (pc 0x200) and id_ready=1 -> next cycle count=0, id_valid=0; 0x200 is never delivered. With IF_ID_PERF_EN, flush_drops increases by 4.
- Full with simultaneous pop: count=4, id_ready=1, if_valid=1 -> no push; count=3 and if_ready=1 next cycle; the push succeeds the following cycle.
